// File: rtl/sprite_blit_engine.sv
// Sprite blitter: streams one SPR_W x SPR_H sprite from a synchronous ROM into
// the frame-buffer write port at one pixel per clock, with draw/erase, transparency and clipping.
module sprite_blit_engine #(
    parameter int         SPR_W     = 22,
    parameter int         SPR_H     = 22,
    parameter int         N_SPRITES = 8,
    parameter int         COLOR_W   = 3,
    parameter int         X_W       = 9,
    parameter int         Y_W       = 8,
    parameter int         SCREEN_W  = 320,
    parameter int         SCREEN_H  = 240,
    parameter logic [COLOR_W-1:0] BG_COLOR = 3'b111,
    parameter logic [COLOR_W-1:0] TRANSP   = 3'b000,
    localparam int        SEL_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
    localparam int        AW        = $clog2(N_SPRITES * SPR_W * SPR_H)
) (
    input  logic               iCLOCK_50,
    input  logic               iresetn,
    input  logic               istart,
    input  logic               ierase,
    input  logic [SEL_W-1:0]   isprite_sel,
    input  logic [X_W-1:0]     ix_pos,
    input  logic [Y_W-1:0]     iy_pos,
    output logic [AW-1:0]      orom_addr,
    input  logic [COLOR_W-1:0] irom_data,
    output logic [X_W-1:0]     ox,
    output logic [Y_W-1:0]     oy,
    output logic [COLOR_W-1:0] ocolor_out,
    output logic               owriteEn,
    output logic               obusy,
    output logic               oDoneSignal,
    output logic [1:0]         odbg_state
);

    localparam int PXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int PYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [PXW-1:0]   PX_LAST  = PXW'(SPR_W - 1);
    localparam logic [PYW-1:0]   PY_LAST  = PYW'(SPR_H - 1);
    localparam logic [AW-1:0]    NPIX_A   = AW'(SPR_W * SPR_H);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(N_SPRITES);
    localparam logic [X_W:0]     SCR_W_L  = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]     SCR_H_L  = (Y_W + 1)'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 erase_q, erase_d;
    logic [X_W-1:0]       x_lat_q, x_lat_d;
    logic [Y_W-1:0]       y_lat_q, y_lat_d;
    logic [PXW-1:0]       px_q, px_d;
    logic [PYW-1:0]       py_q, py_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 flush_q, flush_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [PXW-1:0]       s1_px_q, s1_px_d;
    logic [PYW-1:0]       s1_py_q, s1_py_d;
    logic [X_W-1:0]       ox_q, ox_d;
    logic [Y_W-1:0]       oy_q, oy_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 we_q, we_d;

    logic [X_W:0]         x_sum;
    logic [Y_W:0]         y_sum;
    logic                 on_screen;
    logic                 transparent;

    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) begin
            state_q    <= S_IDLE;
            erase_q    <= 1'b0;
            x_lat_q    <= '0;
            y_lat_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            addr_q     <= '0;
            flush_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_px_q    <= '0;
            s1_py_q    <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            color_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            erase_q    <= erase_d;
            x_lat_q    <= x_lat_d;
            y_lat_q    <= y_lat_d;
            px_q       <= px_d;
            py_q       <= py_d;
            addr_q     <= addr_d;
            flush_q    <= flush_d;
            s1_valid_q <= s1_valid_d;
            s1_px_q    <= s1_px_d;
            s1_py_q    <= s1_py_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            color_q    <= color_d;
            we_q       <= we_d;
        end
    end

    // Control: address generation in RUN, two-cycle drain in FLUSH for the ROM + output stages.
    always_comb begin
        state_d = state_q;
        erase_d = erase_q;
        x_lat_d = x_lat_q;
        y_lat_d = y_lat_q;
        px_d    = px_q;
        py_d    = py_q;
        addr_d  = addr_q;
        flush_d = flush_q;
        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    erase_d = ierase;
                    x_lat_d = ix_pos;
                    y_lat_d = iy_pos;
                    px_d    = '0;
                    py_d    = '0;
                    if ({1'b0, isprite_sel} < SEL_LIM) begin
                        addr_d  = AW'(isprite_sel) * NPIX_A;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (px_q == PX_LAST && py_q == PY_LAST) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (px_q == PX_LAST) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = ~flush_q;
                if (flush_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: stage 1 tracks the pixel whose ROM word arrives next cycle; stage 2 registers the write.
    always_comb begin
        s1_valid_d  = (state_q == S_RUN);
        s1_px_d     = px_q;
        s1_py_d     = py_q;
        x_sum       = {1'b0, x_lat_q} + (X_W + 1)'(s1_px_q);
        y_sum       = {1'b0, y_lat_q} + (Y_W + 1)'(s1_py_q);
        on_screen   = (x_sum < SCR_W_L) && (y_sum < SCR_H_L);
        transparent = !erase_q && (irom_data == TRANSP);
        we_d        = s1_valid_q && on_screen && !transparent;
        ox_d        = ox_q;
        oy_d        = oy_q;
        color_d     = color_q;
        if (s1_valid_q) begin
            ox_d    = x_sum[X_W-1:0];
            oy_d    = y_sum[Y_W-1:0];
            color_d = erase_q ? BG_COLOR : irom_data;
        end
    end

    assign orom_addr   = addr_q;
    assign ox          = ox_q;
    assign oy          = oy_q;
    assign ocolor_out  = color_q;
    assign owriteEn    = we_q;
    assign obusy       = (state_q != S_IDLE);
    assign oDoneSignal = (state_q == S_DONE);
    assign odbg_state  = state_q;

endmodule
